// File: rtl/apb_fsm_controller_if.sv
// Bundle between the AHB slave interface and the APB side of the bridge.
// The master modport is the controller view; the slave modport is the opposite side.
interface apb_fsm_controller_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  logic          valid;
  logic [AW-1:0] Haddr;
  logic [AW-1:0] Haddr1;
  logic [AW-1:0] Haddr2;
  logic [DW-1:0] Hwdata;
  logic [DW-1:0] Hwdata1;
  logic [DW-1:0] Hwdata2;
  logic [DW-1:0] Prdata;
  logic          Hwrite;
  logic          Hwritereg;
  logic [SW-1:0] tempselx;

  logic          Pwrite;
  logic          Penable;
  logic [SW-1:0] Pselx;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pwdata;
  logic          Hreadyout;

  modport master (
    input  valid, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, Hwdata2, Prdata,
           Hwrite, Hwritereg, tempselx,
    output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
  );

  modport slave (
    output valid, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, Hwdata2, Prdata,
           Hwrite, Hwritereg, tempselx,
    input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: SETUP/ENABLE phases plus AHB wait insertion.
// All outputs are registered; the output registers show the phase chosen in the previous state.
module apb_fsm_controller (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  apb_fsm_controller_if.master bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic          pwrite_q, pwrite_d;
  logic          penable_q, penable_d;
  logic [SW-1:0] pselx_q, pselx_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          hreadyout_q, hreadyout_d;

  // Reset is active-high despite the legacy port name.
  always_ff @(posedge Hclk or posedge Hresetn) begin
    if (Hresetn) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pselx_q     <= SW'(0);
      paddr_q     <= AW'(0);
      pwdata_q    <= DW'(0);
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pselx_q     <= pselx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    pselx_d     = pselx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hreadyout_d = hreadyout_q;

    unique case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (bus.valid && !bus.Hwrite) begin
          state_d     = ST_READ;
          paddr_d     = bus.Haddr;
          pwrite_d    = 1'b0;
          pselx_d     = bus.tempselx;
          penable_d   = 1'b0;
          hreadyout_d = 1'b0;
        end else begin
          // Write needs a data-capture cycle first; idle just parks the bus.
          state_d     = bus.valid ? ST_WWAIT : ST_IDLE;
          pselx_d     = SW'(0);
          penable_d   = 1'b0;
          hreadyout_d = 1'b1;
        end
      end
      ST_WWAIT: begin
        state_d     = bus.valid ? ST_WRITEP : ST_WRITE;
        paddr_d     = bus.Haddr1;
        pwrite_d    = 1'b1;
        pselx_d     = bus.tempselx;
        penable_d   = 1'b0;
        pwdata_d    = bus.Hwdata;
        hreadyout_d = 1'b0;
      end
      ST_READ, ST_WRITE, ST_WRITEP: begin
        if (state_q == ST_READ)       state_d = ST_RENABLE;
        else if (state_q == ST_WRITE) state_d = bus.valid ? ST_WENABLEP : ST_WENABLE;
        else                          state_d = ST_WENABLEP;
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
      ST_WENABLEP: begin
        pselx_d     = bus.tempselx;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        // Pipelined write uses the address two AHB cycles back.
        if (bus.Hwritereg) begin
          state_d  = bus.valid ? ST_WRITEP : ST_WRITE;
          paddr_d  = bus.Haddr2;
          pwrite_d = 1'b1;
          pwdata_d = bus.Hwdata;
        end else begin
          state_d  = ST_READ;
          paddr_d  = bus.Haddr;
          pwrite_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Pwrite    = pwrite_q;
  assign bus.Penable   = penable_q;
  assign bus.Pselx     = pselx_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Hreadyout = hreadyout_q;
endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: expected APB outputs are queued with each
// stimulus step and popped for comparison one clock later.
module tb_apb_fsm_controller;
  logic Hclk;
  logic Hresetn;
  apb_fsm_controller_if bus ();

  apb_fsm_controller dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.master)
  );

  typedef struct {
    string       tag;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] prev_psel = 3'b000;

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic pw, input logic pe, input logic [2:0] ps,
                      input logic [31:0] pa, input logic [31:0] pd, input logic hr);
    exp_t e;
    e.tag = tag; e.pwrite = pw; e.penable = pe; e.pselx = ps;
    e.paddr = pa; e.pwdata = pd; e.hready = hr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    chk(e.tag, "Pwrite",    32'(bus.Pwrite),    32'(e.pwrite));
    chk(e.tag, "Penable",   32'(bus.Penable),   32'(e.penable));
    chk(e.tag, "Pselx",     32'(bus.Pselx),     32'(e.pselx));
    chk(e.tag, "Paddr",     bus.Paddr,          e.paddr);
    chk(e.tag, "Pwdata",    bus.Pwdata,         e.pwdata);
    chk(e.tag, "Hreadyout", 32'(bus.Hreadyout), 32'(e.hready));
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
    pop_check();
  endtask

  // Penable must only follow a cycle where a slave was selected.
  always @(negedge Hclk) begin
    if (!Hresetn && bus.Penable) begin
      checks++;
      assert (prev_psel != 3'b000) else begin
        errors++;
        $error("FAIL penable_after_sel observed=prev_psel %b expected=nonzero", prev_psel);
      end
    end
    prev_psel = bus.Pselx;
  end

  initial begin
    Hresetn = 1'b1;
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Hwritereg = 1'b0;
    bus.Haddr = '0; bus.Haddr1 = '0; bus.Haddr2 = '0;
    bus.Hwdata = '0; bus.Hwdata1 = '0; bus.Hwdata2 = '0; bus.Prdata = '0;
    bus.tempselx = 3'b000;

    #10;
    push("reset", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    pop_check();
    #2 Hresetn = 1'b0;
    push("idle_after_reset", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    tick();

    // Single read
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8400_0000; bus.tempselx = 3'b010;
    push("read_setup", 1'b0, 1'b0, 3'b010, 32'h8400_0000, 32'h0, 1'b0);
    tick();
    bus.valid = 1'b0;
    push("read_enable", 1'b0, 1'b1, 3'b010, 32'h8400_0000, 32'h0, 1'b1);
    tick();

    // Read after read, no idle gap
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8800_0000; bus.tempselx = 3'b100;
    push("rar_setup", 1'b0, 1'b0, 3'b100, 32'h8800_0000, 32'h0, 1'b0);
    tick();
    bus.valid = 1'b0;
    push("rar_enable", 1'b0, 1'b1, 3'b100, 32'h8800_0000, 32'h0, 1'b1);
    tick();
    push("rar_to_idle", 1'b0, 1'b0, 3'b000, 32'h8800_0000, 32'h0, 1'b1);
    tick();

    // Single write
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8000_0000; bus.Hwdata = 32'h0;
    push("wr_wait", 1'b0, 1'b0, 3'b000, 32'h8800_0000, 32'h0, 1'b1);
    tick();
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Haddr1 = 32'h8000_0000;
    bus.Hwdata = 32'h1234_5678; bus.tempselx = 3'b001;
    push("wr_setup", 1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h1234_5678, 1'b0);
    tick();
    push("wr_enable", 1'b1, 1'b1, 3'b001, 32'h8000_0000, 32'h1234_5678, 1'b1);
    tick();
    push("wr_to_idle", 1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'h1234_5678, 1'b1);
    tick();

    // Back-to-back writes through WRITEP/WENABLEP
    bus.valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h9000_0000;
    push("p_wait", 1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'h1234_5678, 1'b1);
    tick();
    bus.Haddr = 32'h8C00_0000; bus.Haddr1 = 32'h9000_0000;
    bus.Hwdata = 32'h1111_1111; bus.tempselx = 3'b001;
    push("p_setup1", 1'b1, 1'b0, 3'b001, 32'h9000_0000, 32'h1111_1111, 1'b0);
    tick();
    bus.Hwdata = 32'hDEAD_BEEF;
    push("p_enable1", 1'b1, 1'b1, 3'b001, 32'h9000_0000, 32'h1111_1111, 1'b1);
    tick();
    bus.Hwritereg = 1'b1; bus.valid = 1'b1; bus.Haddr2 = 32'h8C00_0000;
    bus.Hwdata = 32'h8765_4321; bus.tempselx = 3'b011;
    push("p_setup2", 1'b1, 1'b0, 3'b011, 32'h8C00_0000, 32'h8765_4321, 1'b0);
    tick();
    push("p_enable2", 1'b1, 1'b1, 3'b011, 32'h8C00_0000, 32'h8765_4321, 1'b1);
    tick();
    bus.valid = 1'b0; bus.Haddr2 = 32'h8D00_0000; bus.Hwdata = 32'h2222_2222; bus.tempselx = 3'b010;
    push("p_setup3", 1'b1, 1'b0, 3'b010, 32'h8D00_0000, 32'h2222_2222, 1'b0);
    tick();
    bus.Hwritereg = 1'b0;
    push("p_enable3", 1'b1, 1'b1, 3'b010, 32'h8D00_0000, 32'h2222_2222, 1'b1);
    tick();

    // Asynchronous reset during the ENABLE cycle
    Hresetn = 1'b1;
    #1;
    push("async_reset", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    pop_check();
    #1 Hresetn = 1'b0;
    push("post_reset_idle", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    tick();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
